path_point_writer: RTL and testbench

- Sequencer that sits directly upstream of the memory interface decoder and drives its mem_id/address/data/wren bus.
- Accepts a stream of (x, y) path points over a valid/ready handshake. Writes x into XMEM and y into YMEM at the same index, one memory write per cycle.
- Can first clear both memories. Reports point count, completion and truncation to the pathfinding controller.

---
 rtl/path_point_writer.sv | 175 +++++++++++++++++
 tb/tb_path_point_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_point_writer.sv
// path_point_writer
//
// Sequencer in front of the memory interface decoder. It takes (x, y) path
// points from the pathfinding side and writes x into XMEM and y into YMEM at
// the same index, one memory write per cycle. On request it first clears both
// memories to CLEAR_VALUE. It reports the point count, completion and
// truncation back to the pathfinding controller.
//
// Ports:
//   clk, rst_n       system clock (rising edge), asynchronous active-low reset
//   start            one-cycle pulse that begins a new path
//   clear_en         sampled with start: clear both memories before accepting
//   point_valid      point_x / point_y / point_last are valid
//   point_ready      a point is accepted this cycle
//   point_x, point_y coordinates of the offered point
//   point_last       offered point is the final one of the path
//   mem_id, address,
//   data, wren       registered write bus to the decoder
//   point_count      points written in the current path (0..DEPTH)
//   done             path complete, held until the next start
//   overflow         path truncated at DEPTH without point_last
//   dbg_state        current FSM state encoding, for observation only
//
// Handshake: a point transfers on a rising clk edge where point_valid and
// point_ready are both high. point_ready is high only in ARMED while start is
// low; the source must hold its point stable until it transfers.

module path_point_writer #(
    parameter int               DEPTH       = 256,
    parameter int               ADDR_W      = 8,
    parameter int               DATA_W      = 8,
    parameter logic [2:0]       XMEM_ID     = 3'b000,
    parameter logic [2:0]       YMEM_ID     = 3'b001,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear_en,
    input  logic              point_valid,
    output logic              point_ready,
    input  logic [DATA_W-1:0] point_x,
    input  logic [DATA_W-1:0] point_y,
    input  logic              point_last,
    output logic [2:0]        mem_id,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic [ADDR_W:0]   point_count,
    output logic              done,
    output logic              overflow,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR_X = 3'd1,
        CLR_Y = 3'd2,
        ARMED = 3'd3,
        WR_X  = 3'd4,
        WR_Y  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   lat_x;
    logic [DATA_W-1:0]   lat_y;
    logic                lat_last;
    logic                can_start;

    // start is honoured only where no write sequence is in flight.
    assign can_start   = (state == IDLE) || (state == DONE) || (state == ARMED);
    assign point_ready = (state == ARMED) && !start;
    assign dbg_state   = state;

    // Bus outputs are computed from the state being entered, so that the
    // registered bus always matches the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_ptr     <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_last    <= 1'b0;
            point_count <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            mem_id      <= XMEM_ID;
            address     <= '0;
            data        <= '0;
            wren        <= 1'b0;
        end else begin
            mem_id  <= XMEM_ID;
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;

            if (can_start && start) begin
                done        <= 1'b0;
                overflow    <= 1'b0;
                point_count <= '0;
                if (clear_en) begin
                    state   <= CLR_X;
                    clr_ptr <= '0;
                    wren    <= 1'b1;
                    data    <= CLEAR_VALUE;
                end else begin
                    state <= ARMED;
                end
            end else begin
                case (state)
                    CLR_X: begin
                        state   <= CLR_Y;
                        mem_id  <= YMEM_ID;
                        address <= clr_ptr;
                        data    <= CLEAR_VALUE;
                        wren    <= 1'b1;
                    end
                    CLR_Y: begin
                        if (clr_ptr == LAST_ADDR) begin
                            state <= ARMED;
                        end else begin
                            state   <= CLR_X;
                            clr_ptr <= clr_ptr + 1'b1;
                            address <= clr_ptr + 1'b1;
                            data    <= CLEAR_VALUE;
                            wren    <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (point_valid) begin
                            state    <= WR_X;
                            lat_x    <= point_x;
                            lat_y    <= point_y;
                            lat_last <= point_last;
                            address  <= point_count[ADDR_W-1:0];
                            data     <= point_x;
                            wren     <= 1'b1;
                        end
                    end
                    WR_X: begin
                        state   <= WR_Y;
                        mem_id  <= YMEM_ID;
                        address <= point_count[ADDR_W-1:0];
                        data    <= lat_y;
                        wren    <= 1'b1;
                    end
                    WR_Y: begin
                        // WR_Y is never reached with point_count == DEPTH,
                        // so the increment cannot wrap.
                        point_count <= point_count + 1'b1;
                        if (lat_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (point_count + 1'b1 == FULL_CNT) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until start.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_path_point_writer.sv
// Self-checking bench for path_point_writer: directed scenarios with
// hand-computed expected bus writes held in an expected queue.
module tb_path_point_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear_en;
    logic        point_valid;
    logic        point_ready;
    logic [7:0]  point_x;
    logic [7:0]  point_y;
    logic        point_last;
    logic [2:0]  mem_id;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [8:0]  point_count;
    logic        done;
    logic        overflow;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [18:0] exp_q[$];

    path_point_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear_en    (clear_en),
        .point_valid (point_valid),
        .point_ready (point_ready),
        .point_x     (point_x),
        .point_y     (point_y),
        .point_last  (point_last),
        .mem_id      (mem_id),
        .address     (address),
        .data        (data),
        .wren        (wren),
        .point_count (point_count),
        .done        (done),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] wr(input logic [2:0] id, input logic [7:0] a, input logic [7:0] d);
        return {id, a, d};
    endfunction

    // Scoreboard: every bus write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && wren) begin
            if (exp_q.size() == 0) begin
                check("bus_extra_write", 32'(exp_q.size()), 1);
            end else begin
                check("bus_write", {13'd0, mem_id, address, data}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic clr);
        start    = 1'b1;
        clear_en = clr;
        @(posedge clk); #1;
        start    = 1'b0;
        clear_en = 1'b0;
    endtask

    task automatic send_point(input logic [7:0] x, input logic [7:0] y, input logic last);
        logic hs;
        int   budget;
        point_x     = x;
        point_y     = y;
        point_last  = last;
        point_valid = 1'b1;
        hs          = 1'b0;
        budget      = 0;
        while (!hs && budget < 50) begin
            @(negedge clk);
            hs = point_ready;
            @(posedge clk); #1;
            budget++;
        end
        point_valid = 1'b0;
        if (!hs) check("send_handshake", 32'(hs), 1);
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!done && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("done_wait", 32'(done), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int accepts;
        logic rdy;

        rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; point_valid = 1'b0;
        point_x = '0; point_y = '0; point_last = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wren", 32'(wren), 0);
        check("rst_address", 32'(address), 0);
        check("rst_data", 32'(data), 0);
        check("rst_mem_id", 32'(mem_id), 0);
        check("rst_count", 32'(point_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_ready", 32'(point_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three-point path, no clear
        pulse_start(1'b0);
        exp_q.push_back(wr(3'd0, 8'd0, 8'd3)); exp_q.push_back(wr(3'd1, 8'd0, 8'd5));
        exp_q.push_back(wr(3'd0, 8'd1, 8'd4)); exp_q.push_back(wr(3'd1, 8'd1, 8'd6));
        exp_q.push_back(wr(3'd0, 8'd2, 8'd7)); exp_q.push_back(wr(3'd1, 8'd2, 8'd9));
        send_point(8'd3, 8'd5, 1'b0);
        send_point(8'd4, 8'd6, 1'b0);
        send_point(8'd7, 8'd9, 1'b1);
        wait_done();
        check("p3_count", 32'(point_count), 3);
        check("p3_overflow", 32'(overflow), 0);
        check("p3_ready_in_done", 32'(point_ready), 0);
        check("p3_queue_empty", 32'(exp_q.size()), 0);

        // Full clear: 512 writes, point_ready first high in cycle 513
        pulse_start(1'b1);
        for (int a = 0; a < 256; a++) begin
            exp_q.push_back(wr(3'd0, 8'(a), 8'h00));
            exp_q.push_back(wr(3'd1, 8'(a), 8'h00));
        end
        cyc = 1;
        @(negedge clk);
        while (!point_ready && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check("clr_ready_cycle", 32'(cyc), 513);
        check("clr_queue_empty", 32'(exp_q.size()), 0);
        check("clr_count", 32'(point_count), 0);
        check("clr_done", 32'(done), 0);

        // Continuous point_valid: one accept per 3 cycles (now at negedge, ARMED)
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(wr(3'd0, 8'(k), 8'(20 + k)));
            exp_q.push_back(wr(3'd1, 8'(k), 8'(40 + k)));
        end
        accepts     = 0;
        point_x     = 8'd20;
        point_y     = 8'd40;
        point_last  = 1'b0;
        point_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            rdy = point_ready;
            check("stream_ready", 32'(rdy), ((i % 3) == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (rdy) begin
                accepts++;
                point_x = 8'(20 + accepts);
                point_y = 8'(40 + accepts);
            end
        end
        point_valid = 1'b0;
        @(negedge clk);
        check("stream_accepts", 32'(accepts), 3);
        check("stream_count", 32'(point_count), 3);

        // start together with point_valid in ARMED: restart, no accept
        @(posedge clk); #1;
        start = 1'b1; clear_en = 1'b0;
        point_x = 8'd77; point_y = 8'd78; point_last = 1'b0; point_valid = 1'b1;
        @(negedge clk);
        check("restart_ready_low", 32'(point_ready), 0);
        @(posedge clk); #1;
        start = 1'b0; point_valid = 1'b0;
        @(negedge clk);
        check("restart_count", 32'(point_count), 0);
        check("restart_state_armed", 32'(dbg_state), 3);
        exp_q.push_back(wr(3'd0, 8'd0, 8'd99)); exp_q.push_back(wr(3'd1, 8'd0, 8'd98));
        @(posedge clk); #1;
        send_point(8'd99, 8'd98, 1'b1);
        wait_done();
        check("restart_final_count", 32'(point_count), 1);
        check("restart_queue_empty", 32'(exp_q.size()), 0);

        // 255 points + last (index 255) -> done, no overflow; then 256 without last -> overflow
        for (int mode = 0; mode < 2; mode++) begin
            pulse_start(1'b0);
            for (int i = 0; i < 256; i++) begin
                exp_q.push_back(wr(3'd0, 8'(i), 8'(i)));
                exp_q.push_back(wr(3'd1, 8'(i), 8'(255 - i)));
            end
            for (int i = 0; i < 256; i++) begin
                send_point(8'(i), 8'(255 - i), (mode == 0) && (i == 255));
            end
            wait_done();
            check("full_count", 32'(point_count), 256);
            check("full_overflow", 32'(overflow), (mode == 1) ? 32'd1 : 32'd0);
            check("full_queue_empty", 32'(exp_q.size()), 0);
            point_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("full_ready_low", 32'(point_ready), 0);
            end
            @(posedge clk); #1;
            point_valid = 1'b0;
            check("full_count_hold", 32'(point_count), 256);
        end

        // Asynchronous reset during WR_Y
        pulse_start(1'b0);
        exp_q.push_back(wr(3'd0, 8'd0, 8'd5));
        send_point(8'd5, 8'd6, 1'b0);
        @(posedge clk); #1;
        check("wry_wren", 32'(wren), 1);
        check("wry_mem_id", 32'(mem_id), 1);
        rst_n = 1'b0;
        #1;
        check("async_wren", 32'(wren), 0);
        check("async_mem_id", 32'(mem_id), 0);
        check("async_address", 32'(address), 0);
        check("async_data", 32'(data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", 32'(dbg_state), 0);
        check("post_rst_wren", 32'(wren), 0);
        check("post_rst_count", 32'(point_count), 0);
        check("post_rst_done", 32'(done), 0);
        check("post_rst_overflow", 32'(overflow), 0);
        check("post_rst_ready", 32'(point_ready), 0);
        check("post_rst_queue_empty", 32'(exp_q.size()), 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
